// File: rtl/dnn_word_reader.sv
// dnn_word_reader: Avalon-MM pipelined read master for the DNN accelerator.
// Fetches a block of num_words contiguous 32-bit words from a word-aligned
// byte address and returns them in order on a valid/ready stream.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start, i_base_addr,        command strobe and arguments (sampled in IDLE)
//   i_num_words
//   o_busy, o_done               transfer in progress / one-cycle completion pulse
//   o_master_*, i_master_*       Avalon-MM pipelined read master
//   o_out_data, o_out_valid,     output word stream
//   i_out_ready
module dnn_word_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [LEN_W-1:0] i_num_words,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_master_address,
  output logic             o_master_read,
  input  logic             i_master_waitrequest,
  input  logic [31:0]      i_master_readdata,
  input  logic             i_master_readdatavalid,
  output logic [31:0]      o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic             r_read, w_read_nxt;
  logic [LEN_W-1:0] r_issue_cnt, w_issue_nxt;
  logic [LEN_W-1:0] r_ret_cnt, w_ret_nxt;
  logic [CNT_W-1:0] r_outstanding, w_outstanding_nxt;
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] w_fifo_count, w_fifo_count_nxt;
  logic             w_accept, w_push, w_pop, w_empty, w_full, w_credit_nxt;
  logic             r_busy, r_done;

  assign w_accept          = r_read & ~i_master_waitrequest;
  assign w_push            = i_master_readdatavalid;
  assign w_fifo_count      = r_wr_ptr - r_rd_ptr;
  assign w_empty           = (w_fifo_count == {CNT_W{1'b0}});
  assign w_full            = (w_fifo_count == CNT_W'(FIFO_DEPTH));
  assign w_pop             = ~w_empty & i_out_ready;
  assign w_fifo_count_nxt  = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_outstanding_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_push);
  // Credit is judged on next-cycle occupancy so a request raised now already
  // has a FIFO slot reserved; the sum can only shrink until it is accepted.
  assign w_credit_nxt = ({1'b0, w_fifo_count_nxt} + {1'b0, w_outstanding_nxt}) < DEPTH_C;

  // Next-state, address, request and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_read_nxt  = r_read;
    w_issue_nxt = r_issue_cnt;
    if (w_pop) begin
      w_ret_nxt = r_ret_cnt - LEN_W'(1);
    end else begin
      w_ret_nxt = r_ret_cnt;
    end
    case (r_state)
      S_IDLE: begin
        w_read_nxt = 1'b0;
        if (i_start) begin
          if (i_num_words != {LEN_W{1'b0}}) begin
            w_state_nxt = S_ISSUE;
            w_addr_nxt  = i_base_addr & ~32'd3;
            w_issue_nxt = i_num_words;
            w_ret_nxt   = i_num_words;
            w_read_nxt  = w_credit_nxt;
          end else begin
            w_state_nxt = S_FINISH;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_accept) begin
          w_addr_nxt  = r_addr + 32'd4;
          w_issue_nxt = r_issue_cnt - LEN_W'(1);
          if (r_issue_cnt == LEN_W'(1)) begin
            w_read_nxt  = 1'b0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_read_nxt = w_credit_nxt;
          end
        end else if (r_read) begin
          // Stalled request must hold regardless of credit changes.
          w_read_nxt = 1'b1;
        end else begin
          w_read_nxt = w_credit_nxt;
        end
      end
      S_DRAIN: begin
        w_read_nxt = 1'b0;
        if (r_ret_cnt == {LEN_W{1'b0}}) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FINISH: begin
        w_read_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, request, counter and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_addr        <= 32'd0;
      r_read        <= 1'b0;
      r_issue_cnt   <= {LEN_W{1'b0}};
      r_ret_cnt     <= {LEN_W{1'b0}};
      r_outstanding <= {CNT_W{1'b0}};
      r_wr_ptr      <= {(PTR_W + 1){1'b0}};
      r_rd_ptr      <= {(PTR_W + 1){1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_read        <= w_read_nxt;
      r_issue_cnt   <= w_issue_nxt;
      r_ret_cnt     <= w_ret_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_wr_ptr      <= r_wr_ptr + (PTR_W + 1)'(w_push);
      r_rd_ptr      <= r_rd_ptr + (PTR_W + 1)'(w_pop);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (r_state == S_FINISH);
    end
  end

  // Return-buffer storage; cleared on reset so the stream data reads zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_master_readdata;
    end else begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= r_mem[r_wr_ptr[PTR_W-1:0]];
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_master_address = r_addr;
  assign o_master_read    = r_read;
  assign o_out_data       = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_out_valid      = ~w_empty;

  dnn_word_reader_chk u_chk (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_full        (w_full),
    .i_read        (r_read),
    .i_waitrequest (i_master_waitrequest),
    .i_address     (r_addr)
  );

endmodule

// dnn_word_reader_chk: simulation properties for the read master.
// Ports: clock/reset, FIFO push/pop/full, Avalon read/waitrequest/address.
module dnn_word_reader_chk (
  input logic        i_clk,
  input logic        i_rst,
  input logic        i_push,
  input logic        i_pop,
  input logic        i_full,
  input logic        i_read,
  input logic        i_waitrequest,
  input logic [31:0] i_address
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && i_full && !i_pop));

  a_stall_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_read && i_waitrequest) |=> (i_read && $stable(i_address)));

endmodule
